// File: rtl/rv32_if_fetch.sv
// RV32I fetch stage: owns the fetch PC, issues in-order imem requests and buffers words in a 2-entry FIFO.
// Optional IF_ALIGN_CHECK_EN: a misaligned redirect raises fetch_fault_out instead of truncating the target.

module rv32_if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_IW   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        jump_enable_in,
  input  logic [31:0] jump_addr_in,
  input  logic        halt_pipeline_in,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pc_out,
  output logic [31:0] iw_out,
  output logic        fetch_fault_out
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  out_cnt_q, out_cnt_d;
  logic [1:0]  drop_cnt_q, drop_cnt_d;
  logic [1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [31:0] fifo_pc_q [2];
  logic [31:0] fifo_pc_d [2];
  logic [31:0] fifo_iw_q [2];
  logic [31:0] fifo_iw_d [2];
  logic [31:0] pcq_q [2];
  logic [31:0] pcq_d [2];
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] iw_out_q, iw_out_d;
  logic        fault_q;

  logic        pop;
  logic        rsp_take;
  logic        rsp_drop;
  logic        fire;
  logic        fifo_wr_sel;
  logic        pcq_wr_sel;
  logic [2:0]  occupancy;
  logic [2:0]  drop_sum;
  logic [31:0] jump_tgt;
  logic        jump_misaligned;

`ifdef IF_ALIGN_CHECK_EN
  assign jump_tgt        = jump_addr_in;
  assign jump_misaligned = (jump_addr_in[1:0] != 2'b00);

  // The fault is sticky until the next redirect decides afresh.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (jump_enable_in) begin
      fault_q <= jump_misaligned;
    end
  end
`else
  logic align_bits_unused;
  assign align_bits_unused = |jump_addr_in[1:0];
  assign jump_tgt          = {jump_addr_in[31:2], 2'b00};
  assign jump_misaligned   = 1'b0;
  assign fault_q           = 1'b0;
`endif

  assign pop      = !halt_pipeline_in && !fault_q && (fifo_cnt_q != 2'd0);
  assign rsp_drop = imem_rsp_valid && (drop_cnt_q != 2'd0);
  assign rsp_take = imem_rsp_valid && (drop_cnt_q == 2'd0);

  // Credits: buffered plus outstanding words, counting the slot freed by this cycle's pop.
  assign occupancy = {1'b0, fifo_cnt_q} + {1'b0, out_cnt_q} - {2'b00, pop};

  assign imem_req_valid = !reset && !jump_enable_in && !fault_q && (occupancy < 3'd2);
  assign imem_req_addr  = fetch_pc_q;
  assign fire           = imem_req_valid && imem_req_ready;

  assign drop_sum = {1'b0, drop_cnt_q} - {2'b00, rsp_drop}
                  + {1'b0, out_cnt_q}  - {2'b00, rsp_take};

  assign fifo_wr_sel = pop ? (fifo_cnt_q == 2'd2) : (fifo_cnt_q == 2'd1);
  assign pcq_wr_sel  = rsp_take ? (out_cnt_q == 2'd2) : (out_cnt_q == 2'd1);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    fifo_cnt_d = fifo_cnt_q;
    fifo_pc_d  = fifo_pc_q;
    fifo_iw_d  = fifo_iw_q;
    pcq_d      = pcq_q;
    pc_out_d   = pc_out_q;
    iw_out_d   = iw_out_q;

    if (jump_enable_in) begin
      // Every word still owed by memory for the old path must be discarded on arrival.
      fetch_pc_d = jump_tgt;
      out_cnt_d  = 2'd0;
      fifo_cnt_d = 2'd0;
      drop_cnt_d = (drop_sum > 3'd2) ? 2'd2 : drop_sum[1:0];
      pc_out_d   = jump_misaligned ? jump_addr_in : 32'h0;
      iw_out_d   = NOP_IW;
    end else begin
      if (fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      drop_cnt_d = drop_cnt_q - {1'b0, rsp_drop};
      out_cnt_d  = out_cnt_q + {1'b0, fire} - {1'b0, rsp_take};
      fifo_cnt_d = fifo_cnt_q + {1'b0, rsp_take} - {1'b0, pop};

      if (rsp_take) begin
        pcq_d[0] = pcq_q[1];
      end
      if (fire) begin
        pcq_d[pcq_wr_sel] = fetch_pc_q;
      end

      if (pop) begin
        fifo_pc_d[0] = fifo_pc_q[1];
        fifo_iw_d[0] = fifo_iw_q[1];
      end
      if (rsp_take) begin
        fifo_pc_d[fifo_wr_sel] = pcq_q[0];
        fifo_iw_d[fifo_wr_sel] = imem_rsp_data;
      end

      if (!halt_pipeline_in && !fault_q) begin
        if (fifo_cnt_q != 2'd0) begin
          pc_out_d = fifo_pc_q[0];
          iw_out_d = fifo_iw_q[0];
        end else begin
          pc_out_d = 32'h0;
          iw_out_d = NOP_IW;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q   <= RESET_PC;
      out_cnt_q    <= 2'd0;
      drop_cnt_q   <= 2'd0;
      fifo_cnt_q   <= 2'd0;
      fifo_pc_q[0] <= 32'h0;
      fifo_pc_q[1] <= 32'h0;
      fifo_iw_q[0] <= 32'h0;
      fifo_iw_q[1] <= 32'h0;
      pcq_q[0]     <= 32'h0;
      pcq_q[1]     <= 32'h0;
      pc_out_q     <= 32'h0;
      iw_out_q     <= NOP_IW;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      fifo_pc_q  <= fifo_pc_d;
      fifo_iw_q  <= fifo_iw_d;
      pcq_q      <= pcq_d;
      pc_out_q   <= pc_out_d;
      iw_out_q   <= iw_out_d;
    end
  end

  assign pc_out          = pc_out_q;
  assign iw_out          = iw_out_q;
  assign fetch_fault_out = fault_q;

endmodule

// File: tb/tb_rv32_if_fetch.sv
// Bench for rv32_if_fetch: directed scenarios plus a randomized run against an in-order memory
// model and a stream-level expectation of which PCs decode must see.

module tb_rv32_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        jump_enable_in;
  logic [31:0] jump_addr_in;
  logic        halt_pipeline_in;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] pc_out;
  logic [31:0] iw_out;
  logic        fetch_fault_out;

  int total = 0;
  int bad = 0;

  // Memory model: in-order queue of accepted requests, each due a fixed latency later.
  logic [31:0] memAddr [$];
  int          memDue [$];
  bit          memStale [$];
  int          memLat;
  int          cyc;

  // Stream-level expectations.
  logic [31:0] expIssue;
  logic [31:0] expOut;
  int          live;
  int          delivered;
  logic [31:0] prevPc;
  logic [31:0] prevIw;
  bit          heldPending;
  logic [31:0] heldAddr;
  bit          faultExp;
  logic        lastReqValid;
  logic [31:0] lastReqAddr;

  always #5 clk = ~clk;

  rv32_if_fetch #(.RESET_PC(32'h0000_0100), .NOP_IW(NOP)) dut (
    .clk              (clk),
    .reset            (reset),
    .jump_enable_in   (jump_enable_in),
    .jump_addr_in     (jump_addr_in),
    .halt_pipeline_in (halt_pipeline_in),
    .imem_req_valid   (imem_req_valid),
    .imem_req_addr    (imem_req_addr),
    .imem_req_ready   (imem_req_ready),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .pc_out           (pc_out),
    .iw_out           (iw_out),
    .fetch_fault_out  (fetch_fault_out)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return ~a;
  endfunction

  function automatic int countStale();
    int n = 0;
    foreach (memStale[i]) if (memStale[i]) n++;
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    memAddr.delete();
    memDue.delete();
    memStale.delete();
    expIssue    = 32'h100;
    expOut      = 32'h100;
    live        = 0;
    prevPc      = 32'h0;
    prevIw      = NOP;
    heldPending = 1'b0;
    faultExp    = 1'b0;
  endtask

  // One clock cycle: called just after a falling edge, returns at the next falling edge.
  task automatic applyStimulus(input bit jmp, input logic [31:0] addr, input bit hlt, input bit rdy);
    bit          rspNow;
    logic        sv;
    logic [31:0] sa;
    jump_enable_in   = jmp;
    jump_addr_in     = addr;
    halt_pipeline_in = hlt;
    imem_req_ready   = rdy;
    rspNow = (memDue.size() > 0) && (memDue[0] <= cyc);
    imem_rsp_valid = rspNow;
    imem_rsp_data  = rspNow ? memWord(memAddr[0]) : 32'hDEAD_BEEF;
    #1;
    sv = imem_req_valid;
    sa = imem_req_addr;
    lastReqValid = sv;
    lastReqAddr  = sa;
    if (jmp) checkOutput("noReqOnJump", {31'b0, sv}, 32'd0);
    if (heldPending && !jmp) begin
      checkOutput("reqHeldValid", {31'b0, sv}, 32'd1);
      checkOutput("reqHeldAddr", sa, heldAddr);
    end
    if (sv) checkOutput("reqAddr", sa, expIssue);

    @(posedge clk);
    if (rspNow) begin
      void'(memAddr.pop_front());
      void'(memDue.pop_front());
      void'(memStale.pop_front());
    end
    if (sv && rdy) begin
      memAddr.push_back(sa);
      memDue.push_back(cyc + memLat);
      memStale.push_back(1'b0);
      expIssue = sa + 32'd4;
      live++;
    end
    heldPending = sv && !rdy && !jmp;
    heldAddr    = sa;
    if (jmp) begin
      foreach (memStale[i]) memStale[i] = 1'b1;
`ifdef IF_ALIGN_CHECK_EN
      faultExp = (addr[1:0] != 2'b00);
      expIssue = addr;
      expOut   = addr;
`else
      faultExp = 1'b0;
      expIssue = addr & 32'hFFFF_FFFC;
      expOut   = addr & 32'hFFFF_FFFC;
`endif
      live = 0;
    end
    cyc++;

    #1;
    if (jmp) begin
      checkOutput("jumpPc", pc_out, faultExp ? addr : 32'h0);
      checkOutput("jumpIw", iw_out, NOP);
    end else if (hlt || faultExp) begin
      checkOutput("holdPc", pc_out, prevPc);
      checkOutput("holdIw", iw_out, prevIw);
    end else if (!(pc_out === 32'h0 && iw_out === NOP)) begin
      checkOutput("outPc", pc_out, expOut);
      checkOutput("outIw", iw_out, memWord(expOut));
      expOut = expOut + 32'd4;
      live--;
      delivered++;
    end
    checkOutput("fault", {31'b0, fetch_fault_out}, {31'b0, faultExp});
    checkOutput("credit", 32'(live <= 2), 32'd1);
    prevPc = pc_out;
    prevIw = iw_out;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] held;
    bit          found;
    int          dlv0;

    reset            = 1'b1;
    jump_enable_in   = 1'b0;
    jump_addr_in     = 32'h0;
    halt_pipeline_in = 1'b0;
    imem_req_ready   = 1'b1;
    imem_rsp_valid   = 1'b0;
    imem_rsp_data    = 32'h0;
    memLat           = 1;
    cyc              = 0;
    delivered        = 0;
    resetModel();

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstPc", pc_out, 32'h0);
    checkOutput("rstIw", iw_out, NOP);
    checkOutput("rstReqValid", {31'b0, imem_req_valid}, 32'd0);
    checkOutput("rstFault", {31'b0, fetch_fault_out}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] reset release and streaming");
    applyStimulus(0, 0, 0, 1);
    checkOutput("firstReqValid", {31'b0, lastReqValid}, 32'd1);
    checkOutput("firstReqAddr", lastReqAddr, 32'h100);
    checkOutput("bubble0", iw_out, NOP);
    applyStimulus(0, 0, 0, 1);
    checkOutput("bubble1", pc_out, 32'h0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("stream0", pc_out, 32'h100);
    applyStimulus(0, 0, 0, 1);
    checkOutput("stream1", pc_out, 32'h104);
    applyStimulus(0, 0, 0, 1);
    checkOutput("stream2", pc_out, 32'h108);
    checkOutput("stream2Iw", iw_out, memWord(32'h108));

    $display("[TB] halt for 3 cycles");
    held = pc_out;
    repeat (3) applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("haltResume", pc_out, held + 32'd4);

    $display("[TB] memory not ready for 4 cycles");
    repeat (4) applyStimulus(0, 0, 0, 0);
    checkOutput("drainPc", pc_out, 32'h0);
    checkOutput("drainIw", iw_out, NOP);
    checkOutput("drainReqValid", {31'b0, lastReqValid}, 32'd1);
    repeat (4) applyStimulus(0, 0, 0, 1);

    $display("[TB] redirect with 3-cycle memory");
    memLat = 3;
    repeat (6) applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 32'h200, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("redirReqAddr", lastReqAddr, 32'h200);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(0, 0, 0, 1);
      if (!(pc_out === 32'h0 && iw_out === NOP)) found = 1'b1;
    end
    checkOutput("redirSeen", {31'b0, found}, 32'd1);
    checkOutput("redirFirstPc", pc_out, 32'h200);

    $display("[TB] back-to-back redirects");
    repeat (6) applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 32'h300, 0, 1);
    applyStimulus(1, 32'h400, 0, 1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(0, 0, 0, 1);
      if (!(pc_out === 32'h0 && iw_out === NOP)) found = 1'b1;
    end
    checkOutput("b2bSeen", {31'b0, found}, 32'd1);
    checkOutput("b2bFirstPc", pc_out, 32'h400);

    $display("[TB] redirect latency and PC wrap");
    memLat = 1;
    repeat (8) applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 32'hFFFF_FFF8, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("wrapReqAddr", lastReqAddr, 32'hFFFF_FFF8);
    checkOutput("wrapBubbleR", pc_out, 32'h0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("wrapBubbleR1", iw_out, NOP);
    applyStimulus(0, 0, 0, 1);
    checkOutput("wrapPc0", pc_out, 32'hFFFF_FFF8);
    applyStimulus(0, 0, 0, 1);
    checkOutput("wrapPc1", pc_out, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 1);
    checkOutput("wrapPc2", pc_out, 32'h0);
    checkOutput("wrapIw2", iw_out, memWord(32'h0));

    $display("[TB] misaligned redirect");
    applyStimulus(1, 32'h202, 0, 1);
`ifdef IF_ALIGN_CHECK_EN
    checkOutput("faultSet", {31'b0, fetch_fault_out}, 32'd1);
    checkOutput("faultPc", pc_out, 32'h202);
    checkOutput("faultIw", iw_out, NOP);
    repeat (3) begin
      applyStimulus(0, 0, 0, 1);
      checkOutput("faultNoReq", {31'b0, lastReqValid}, 32'd0);
    end
    applyStimulus(1, 32'h300, 0, 1);
    checkOutput("faultClear", {31'b0, fetch_fault_out}, 32'd0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("faultNextReq", lastReqAddr, 32'h300);
`else
    checkOutput("alignNoFault", {31'b0, fetch_fault_out}, 32'd0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("alignReqAddr", lastReqAddr, 32'h200);
`endif
    repeat (4) applyStimulus(0, 0, 0, 1);

    $display("[TB] randomized traffic");
    dlv0 = delivered;
    for (int i = 0; i < 400; i++) begin
      bit          j;
      logic [31:0] a;
      if (i % 50 == 0) memLat = $urandom_range(1, 3);
      j = ($urandom_range(0, 15) == 0) && (countStale() == 0);
      a = 32'($urandom_range(0, 16'h3FFF)) << 2;
      applyStimulus(j, a, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
    end
    checkOutput("progress", 32'(delivered - dlv0 > 20), 32'd1);

    $display("[TB] asynchronous reset mid-stream");
    memLat = 1;
    repeat (5) applyStimulus(0, 0, 0, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("asyncRstPc", pc_out, 32'h0);
    checkOutput("asyncRstIw", iw_out, NOP);
    checkOutput("asyncRstReq", {31'b0, imem_req_valid}, 32'd0);
    resetModel();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 1);
    checkOutput("postRstReqAddr", lastReqAddr, 32'h100);
    repeat (4) applyStimulus(0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32_if_fetch.md
# rv32_if_fetch

Instruction-fetch stage of the RV32I 5-stage pipeline, directly upstream of the decode stage. It owns the fetch PC, issues in-order requests to instruction memory over a valid/ready request and valid-only response channel, and buffers returned words in a 2-entry FIFO. It presents registered `pc_out`/`iw_out` to decode, freezes them while decode halts the pipeline, and redirects on decode's jump/branch resolution, discarding all in-flight and buffered fetches.

## Interface

- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP_IW`, 32'h0000_0013, bubble instruction word (addi x0,x0,0)

- `clk` input 1: clock, rising edge
- `reset` input 1: asynchronous, active-high reset
- `jump_enable_in` input 1: redirect request from decode, combinational in decode
- `jump_addr_in` input 32: redirect target
- `halt_pipeline_in` input 1: decode stall; hold outputs
- `imem_req_valid` output 1: fetch request valid
- `imem_req_addr` output 32: fetch address, word aligned
- `imem_req_ready` input 1: memory accepts request this cycle
- `imem_rsp_valid` input 1: response word valid, in request order, latency >= 1 cycle
- `imem_rsp_data` input 32: instruction word
- `pc_out` output 32: PC of `iw_out`
- `iw_out` output 32: instruction to decode
- `fetch_fault_out` output 1: `iw_out` is a bubble caused by a misaligned redirect (macro only; else tied 0)

## Operation

- State: `fetch_pc`, `outstanding` (0..2), `drop_cnt` (0..2), FIFO {pc, iw} x2 with `fifo_cnt` (0..2).
- Issue: `imem_req_valid` = `fifo_cnt + outstanding - pop < 2` and not `jump_enable_in`. Handshake completes on `valid && ready`; then `outstanding++`, `fetch_pc += 4`. `imem_req_addr` = `fetch_pc`, held stable while valid and not ready.
- Response: if `drop_cnt > 0`, decrement `drop_cnt`, discard word; else push {pc of oldest request, data} into FIFO and `outstanding--`. The responded PC is tracked by a 2-entry PC queue written at issue.
- Pop: when `!halt_pipeline_in` and `fifo_cnt > 0`, load head into `pc_out`/`iw_out`. When `!halt_pipeline_in` and FIFO empty, load `pc_out`=0, `iw_out`=`NOP_IW`.
- Halt: `pc_out`/`iw_out` hold; no pop; fetch continues until credits exhausted.
- Redirect (`jump_enable_in`=1): at the clock edge, FIFO cleared, `drop_cnt <= outstanding` (minus 1 if a non-dropped response arrives the same cycle), `outstanding <= 0`, `fetch_pc <= jump_addr_in`, `pc_out`=0, `iw_out`=`NOP_IW`. No request issued in the redirect cycle. Redirect overrides halt.
- Priority: reset > redirect > halt > normal.
- PC arithmetic: 32-bit modulo; 0xFFFF_FFFC + 4 wraps to 0.
- Stale responses while `drop_cnt > 0` never enter the FIFO, including across back-to-back redirects (`drop_cnt` accumulates, saturating at 2).

## Timing

- Reset values: `pc_out`=0, `iw_out`=`NOP_IW`, `imem_req_valid`=0, `fetch_fault_out`=0, `fetch_pc`=`RESET_PC`, all counters 0, FIFO empty.
- First request: the first cycle after `reset` deasserts.
- Fetch-to-output latency: a response valid in cycle N is in the FIFO in N+1 and on `iw_out` in N+2 (no halt).
- Throughput: 1 instruction/cycle with 1-cycle memory latency and `imem_req_ready`=1.
- Redirect: the first request to the target is issued in the cycle after `jump_enable_in`. The target instruction reaches `iw_out` 3 cycles after that request (1-cycle memory).
- Reset mid-operation clears all state asynchronously. Responses to pre-reset requests are the memory's responsibility (memory is reset together with this stage).

## Configuration

- `IF_ALIGN_CHECK_EN` defined: a redirect whose `jump_addr_in[1:0]` != 0 sets `fetch_fault_out`=1 with `iw_out`=`NOP_IW` and `pc_out`=`jump_addr_in`. No fetch is issued until the next redirect; `fetch_fault_out` stays 1 until that redirect or reset.
- Undefined: `jump_addr_in[1:0]` is forced to 0 and `fetch_fault_out` is tied 0.

## Test plan

- Reset with `RESET_PC`=0x100: all outputs at reset values. First `imem_req_addr`=0x100 one cycle after release; with 1-cycle memory, `iw_out` streams 0x100, 0x104, 0x108 on consecutive cycles.
- `halt_pipeline_in` high 3 cycles while streaming: `pc_out`/`iw_out` frozen, at most 2 requests outstanding or buffered. On release, the next sequential PC appears with no gap or duplicate.
- Redirect to 0x200 with 2 requests in flight (3-cycle memory latency): both stale responses dropped. The next non-bubble `pc_out` is 0x200, and `iw_out` is a NOP until then.
- `imem_req_ready` low 4 cycles: `imem_req_addr` stable and `imem_req_valid` held. Decode receives NOP bubbles with `pc_out`=0 once the FIFO drains.
- Back-to-back redirects to 0x300, then 0x400, with 2 in flight: only the 0x400 stream reaches `iw_out`.
- With `IF_ALIGN_CHECK_EN`, redirect to 0x202: `fetch_fault_out`=1, `pc_out`=0x202, `iw_out`=0x13, no requests issued. A later redirect to 0x300 clears the fault.
